// File: rtl/btn_press_gen.sv
// btn_press_gen: turns single-clk request strobes into clean button presses.
// Each accepted request yields btn=1 for HOLD_TICKS ce periods followed by at
// least GAP_TICKS low ce periods. Requests that arrive while a press is in
// flight are counted in pend (up to MAX_PEND). A request that arrives while
// the queue is full is dropped, and ovf pulses for one clk.
// Optional feature macro: BTN_BOUNCE_EN. When it is defined, btn shows LFSR
// noise for the first BNC_TICKS ce ticks of every PRESS and GAP phase.
module btn_press_gen #(
  parameter int HOLD_TICKS = 50,
  parameter int GAP_TICKS  = 50,
  parameter int MAX_PEND   = 7,
  parameter int CNT_W      = 8,
  parameter int BNC_TICKS  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic                            st,
  output logic                            btn,
  output logic                            busy,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend,
  output logic                            ovf
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [PW-1:0]    PEND_MAX  = PW'(MAX_PEND);

  // Catch parameter sets that cannot work at elaboration time.
  if (HOLD_TICKS < 1 || HOLD_TICKS > (1 << CNT_W)) begin : g_bad_hold
    $error("btn_press_gen: HOLD_TICKS out of range");
  end
  if (GAP_TICKS < 1 || GAP_TICKS > (1 << CNT_W)) begin : g_bad_gap
    $error("btn_press_gen: GAP_TICKS out of range");
  end
  if (MAX_PEND < 1) begin : g_bad_pend
    $error("btn_press_gen: MAX_PEND must be at least 1");
  end
  if (BNC_TICKS >= HOLD_TICKS || BNC_TICKS >= GAP_TICKS) begin : g_bad_bnc
    $error("btn_press_gen: BNC_TICKS must be below HOLD_TICKS and GAP_TICKS");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              btn_q, btn_d;
  logic              busy_q;
  logic [PW-1:0]     pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              start_d;    // a press would start if this were a ce edge
  logic              dec;        // a press really starts on this edge

`ifdef BTN_BOUNCE_EN
  localparam logic [CNT_W-1:0] BNC_LOAD = CNT_W'(BNC_TICKS - 1);
  logic [7:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  bnc_q, bnc_d;
  logic              win_q, win_d;
`endif

  // Phase sequencing that takes effect on a ce edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) begin
          state_d = ST_PRESS;
          cnt_d   = HOLD_LOAD;
          start_d = 1'b1;
        end
      end
      ST_PRESS: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pend_q != '0) begin
          state_d = ST_PRESS;
          cnt_d   = HOLD_LOAD;
          start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dec = ce & start_d;

  // Request queue bookkeeping, evaluated on every clk
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (st && !dec) begin
      if (pend_q < PEND_MAX) begin
        pend_d = pend_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (!st && dec) begin
      pend_d = pend_q - 1'b1;
    end
  end

`ifdef BTN_BOUNCE_EN
  // Bounce window tracking and the noisy level shown inside it
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    win_d  = 1'b0;
    bnc_d  = bnc_q;
    if (state_d != state_q && state_d != ST_IDLE) begin
      win_d = 1'b1;
      bnc_d = BNC_LOAD;
    end else if (state_d != ST_IDLE && win_q && bnc_q != '0) begin
      win_d = 1'b1;
      bnc_d = bnc_q - 1'b1;
    end
    btn_d = win_d ? lfsr_d[0] : (state_d == ST_PRESS);
  end
`else
  // Clean level: high exactly while the next phase is PRESS
  always_comb begin
    btn_d = (state_d == ST_PRESS);
  end
`endif

  // Registered state. The queue moves every clk; the phase moves only on ce
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef BTN_BOUNCE_EN
      lfsr_q  <= 8'hA5;
      bnc_q   <= '0;
      win_q   <= 1'b0;
`endif
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (ce) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        btn_q   <= btn_d;
        busy_q  <= (state_d != ST_IDLE);
`ifdef BTN_BOUNCE_EN
        lfsr_q  <= lfsr_d;
        bnc_q   <= bnc_d;
        win_q   <= win_d;
`endif
      end
    end
  end

  assign btn  = btn_q;
  assign busy = busy_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule
